pwm_out_gen: RTL and testbench

- Consumer end of the per-LED ramp interface. Takes NUM_CH packed 5-bit duty values, one per LED ramp state machine, and produces glitch-free PWM waveforms on the LED pins.
- Also generates the `tick` strobe that paces the ramp state machines: one pulse per PWM period, so each ramp changes duty at most once per period.
- Sits between the knight-rider sequencer/ramp bank and the board LED outputs.

---
 rtl/pwm_out_gen.sv | 91 +++++++++
 tb/tb_pwm_out_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_out_gen.sv
// pwm_out_gen: NUM_CH-channel PWM driver plus the per-period tick that paces the LED ramps.
// Ports: clk, rst (async active-low), en, duty[NUM_CH*DUTY_W], pwm_out[NUM_CH], tick, period_start. Option: PWM_GAMMA_EN.
module pwm_out_gen #(
  parameter int NUM_CH   = 8,
  parameter int DUTY_W   = 5,
  parameter int PRESCALE = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_CH*DUTY_W-1:0] duty,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic                     tick,
  output logic                     period_start
);

`ifdef PWM_GAMMA_EN
  localparam int STEP_W = 8;
  localparam int MAX    = 254;
`else
  localparam int STEP_W = DUTY_W;
  localparam int MAX    = (1 << DUTY_W) - 2;
`endif
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]  pre_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic [STEP_W-1:0] step_nxt;
  logic [STEP_W-1:0] duty_lat [NUM_CH];
  logic [STEP_W-1:0] lat_nxt  [NUM_CH];
  logic [NUM_CH-1:0] pwm_nxt;
  logic              step;
  logic              wrap;

  // Duty mapping applied as the value is latched, so the compare stays a plain magnitude compare.
  function automatic logic [STEP_W-1:0] map_duty(input logic [DUTY_W-1:0] d);
`ifdef PWM_GAMMA_EN
    logic [31:0] p;
    p = (32'(d) * 32'(d) * 32'd255) / 32'd961;
    return STEP_W'(p);
`else
    return d;
`endif
  endfunction

  // Next-state values are computed once and reused for pwm_out, so the
  // output lines up with the registered counters without extra latency.
  always_comb begin
    step = (pre_cnt == PRE_W'(PRESCALE - 1));
    wrap = step && (step_cnt == STEP_W'(MAX));
    step_nxt = step_cnt;
    if (!en)
      step_nxt = '0;
    else if (wrap)
      step_nxt = '0;
    else if (step)
      step_nxt = step_cnt + STEP_W'(1);
    pwm_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!en || wrap)
        lat_nxt[i] = map_duty(duty[i*DUTY_W +: DUTY_W]);
      else
        lat_nxt[i] = duty_lat[i];
      pwm_nxt[i] = en && (step_nxt < lat_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt      <= '0;
      step_cnt     <= '0;
      pwm_out      <= '0;
      tick         <= 1'b0;
      period_start <= 1'b0;
      for (int i = 0; i < NUM_CH; i++)
        duty_lat[i] <= '0;
    end else begin
      if (!en || step)
        pre_cnt <= '0;
      else
        pre_cnt <= pre_cnt + PRE_W'(1);
      step_cnt     <= step_nxt;
      pwm_out      <= pwm_nxt;
      tick         <= en && wrap;
      period_start <= en && wrap;
      for (int i = 0; i < NUM_CH; i++)
        duty_lat[i] <= lat_nxt[i];
    end
  end

endmodule

// File: tb/tb_pwm_out_gen.sv
// tb_pwm_out_gen: directed bench for pwm_out_gen.
// Linear build uses PRESCALE=4; with PWM_GAMMA_EN it runs the gamma cases at PRESCALE=1.
module tb_pwm_out_gen;

`ifdef PWM_GAMMA_EN
  localparam int PRE = 1;
`else
  localparam int PRE = 4;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic [39:0] duty;
  logic [7:0]  pwm_out;
  logic        tick;
  logic        period_start;

  int errs = 0;
  int checks = 0;
  int n, hs, ts;
  int hi_cnt [8];
  int first_low [8];
  int n_tick, ps_bad;

  pwm_out_gen #(.NUM_CH(8), .DUTY_W(5), .PRESCALE(PRE)) dut (
    .clk(clk), .rst(rst), .en(en), .duty(duty),
    .pwm_out(pwm_out), .tick(tick), .period_start(period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_duty(input int ch, input int v);
    duty[ch*5 +: 5] = 5'(v);
  endtask

  // Counts cycles until tick; hi counts non-tick samples with any pwm high.
  task automatic wait_tick(output int cnt, output int hi);
    cnt = 0;
    hi = 0;
    do begin
      cyc();
      cnt++;
      if (!tick && pwm_out != 0) hi++;
    end while (!tick && cnt < 1200);
  endtask

  // Starts on a tick sample and observes one full period.
  task automatic period(input int len, input int chg_at, input int chg_val);
    for (int c = 0; c < 8; c++) begin
      hi_cnt[c] = 0;
      first_low[c] = -1;
    end
    n_tick = 0;
    ps_bad = 0;
    for (int k = 0; k < len; k++) begin
      if (k == chg_at) set_duty(0, chg_val);
      for (int c = 0; c < 8; c++) begin
        if (pwm_out[c]) hi_cnt[c]++;
        else if (first_low[c] < 0) first_low[c] = k;
      end
      if (tick) n_tick++;
      if (period_start !== tick) ps_bad++;
      cyc();
    end
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b0;
    duty = '0;
    repeat (3) cyc();
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_ps", int'(period_start), 0);
`ifdef PWM_GAMMA_EN
    set_duty(0, 16);
    set_duty(1, 1);
    set_duty(2, 31);
    rst = 1'b1;
    en = 1'b1;
    wait_tick(n, hs);
    chk("g_first_tick", n, 255);
    chk("g_pre_tick_pwm", hs, 0);
    repeat (2) begin
      period(255, -1, 0);
      chk("g_hi16", hi_cnt[0], 67);
      chk("g_low16", first_low[0], 67);
      chk("g_hi1", hi_cnt[1], 0);
      chk("g_hi31", hi_cnt[2], 255);
      chk("g_ticks", n_tick, 1);
      chk("g_ps", ps_bad, 0);
    end
`else
    set_duty(0, 10);
    set_duty(1, 0);
    set_duty(2, 31);
    set_duty(3, 5);
    set_duty(5, 30);
    rst = 1'b1;
    en = 1'b1;
    wait_tick(n, hs);
    chk("first_tick", n, 124);
    chk("pre_tick_pwm", hs, 0);
    chk("tick_pwm0", int'(pwm_out[0]), 1);
    chk("tick_pwm1", int'(pwm_out[1]), 0);
    repeat (3) begin
      period(124, -1, 0);
      chk("hi0", hi_cnt[0], 40);
      chk("low0", first_low[0], 40);
      chk("hi1", hi_cnt[1], 0);
      chk("hi2", hi_cnt[2], 124);
      chk("hi3", hi_cnt[3], 20);
      chk("hi5", hi_cnt[5], 120);
      chk("ticks", n_tick, 1);
      chk("ps", ps_bad, 0);
      chk("wrap_tick", int'(tick), 1);
      chk("wrap_pwm2", int'(pwm_out[2]), 1);
      chk("wrap_pwm0", int'(pwm_out[0]), 1);
    end
    period(124, 60, 20);
    chk("mid_hi0", hi_cnt[0], 40);
    chk("mid_ticks", n_tick, 1);
    period(124, -1, 0);
    chk("new_hi0", hi_cnt[0], 80);
    chk("new_low0", first_low[0], 80);
    chk("pre_rst_tick", int'(tick), 1);
    chk("pre_rst_pwm0", int'(pwm_out[0]), 1);
    #1 rst = 1'b0;
    #1;
    chk("arst_pwm", int'(pwm_out), 0);
    chk("arst_tick", int'(tick), 0);
    chk("arst_ps", int'(period_start), 0);
    @(posedge clk);
    #1;
    set_duty(0, 10);
    rst = 1'b1;
    wait_tick(n, hs);
    chk("rec_first_tick", n, 124);
    chk("rec_pre_tick_pwm", hs, 0);
    period(124, -1, 0);
    chk("rec_hi0", hi_cnt[0], 40);
    en = 1'b0;
    set_duty(0, 5);
    cyc();
    chk("en0_pwm", int'(pwm_out), 0);
    chk("en0_tick", int'(tick), 0);
    hs = 0;
    ts = 0;
    repeat (49) begin
      cyc();
      if (pwm_out != 0) hs++;
      if (tick || period_start) ts++;
    end
    chk("en0_hi", hs, 0);
    chk("en0_ticks", ts, 0);
    en = 1'b1;
    cyc();
    chk("en1_pwm0", int'(pwm_out[0]), 1);
    chk("en1_pwm1", int'(pwm_out[1]), 0);
    chk("en1_tick", int'(tick), 0);
    n = 1;
    while (!tick && n < 400) begin
      cyc();
      n++;
    end
    chk("en1_first_tick", n, 124);
    period(124, -1, 0);
    chk("en1_hi0", hi_cnt[0], 20);
    repeat (30) cyc();
    en = 1'b0;
    cyc();
    chk("drop_pwm", int'(pwm_out), 0);
    chk("drop_tick", int'(tick), 0);
    ts = 0;
    repeat (200) begin
      cyc();
      if (tick || period_start) ts++;
    end
    chk("drop_ticks", ts, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
